multi_lane_tri_accum: RTL

//  Parametrised, multi-lane triangular accumulator: per lane, x <= x + y; y <= y + STEP while enabled and y < LIMIT.

---
 rtl/multi_lane_tri_accum.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multi_lane_tri_accum.sv
// multi_lane_tri_accum
//   Multi-lane triangular accumulator. While a lane is enabled in RUN and its
//   counter y is still below LIMIT, it adds y into its accumulator x and then
//   advances y by STEP. The block also provides load/restart control, wrap or
//   saturating arithmetic on x, sticky overflow flags and per-lane done flags.
//
//   Optional feature macro: ACCUM_INV_CHK_EN
//     When defined, adds the inv_err output. inv_err[i] is a sticky monitor
//     that sets when lane i is done and x < y.
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset; takes priority over everything
//   start     loads init_x/init_y into all lanes and enters RUN
//   sat_mode  0: x wraps modulo 2**XW; 1: x saturates at all-ones
//   sel       per-lane step enable
//   init_x    x load value, shared by all lanes
//   init_y    y load value, shared by all lanes
//   x_o       lane i x at [i*XW +: XW]
//   y_o       lane i y at [i*YW +: YW]
//   done      lane i has reached y >= LIMIT since the last load
//   ovf       sticky flag: lane i x overflowed since the last load
//   busy      high while in RUN
//   inv_err   (ACCUM_INV_CHK_EN only) sticky flag: done and x < y seen
module multi_lane_tri_accum #(
  parameter int NCH   = 1,
  parameter int XW    = 16,
  parameter int YW    = 16,
  parameter int LIMIT = 200,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sat_mode,
  input  logic [NCH-1:0]    sel,
  input  logic [XW-1:0]     init_x,
  input  logic [YW-1:0]     init_y,
  output logic [NCH*XW-1:0] x_o,
  output logic [NCH*YW-1:0] y_o,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    ovf,
  output logic              busy
`ifdef ACCUM_INV_CHK_EN
  ,
  output logic [NCH-1:0]    inv_err
`endif
);

  localparam logic [YW-1:0] LIMIT_Y = YW'(LIMIT);
  localparam logic [YW-1:0] STEP_Y  = YW'(STEP);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A start pulse while in RUN reloads the lanes and keeps the FSM in RUN.
  // It takes precedence over the all-done exit to FIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (!start && (&done)) state_nxt = FIN;
      FIN:     if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    logic [XW-1:0] x_q, x_nxt;
    logic [YW-1:0] y_q, y_nxt;
    logic [XW:0]   x_sum;
    logic [YW:0]   y_sum;
    logic          step;
    logic          done_q, done_nxt;
    logic          ovf_q, ovf_nxt;

    always_comb begin
      x_sum    = {1'b0, x_q} + {1'b0, XW'(y_q)};
      y_sum    = {1'b0, y_q} + {1'b0, STEP_Y};
      step     = (state == RUN) && sel[i] && (y_q < LIMIT_Y);
      x_nxt    = x_q;
      y_nxt    = y_q;
      ovf_nxt  = ovf_q;
      done_nxt = done_q;
      if (step) begin
        if (x_sum[XW]) begin
          x_nxt   = sat_mode ? {XW{1'b1}} : x_sum[XW-1:0];
          ovf_nxt = 1'b1;
        end else begin
          x_nxt = x_sum[XW-1:0];
        end
        // y clamps at all-ones rather than wrapping back below LIMIT
        y_nxt = y_sum[YW] ? {YW{1'b1}} : y_sum[YW-1:0];
      end
      // done follows the next-state y, so a lane loaded at or above LIMIT
      // reports done on its first RUN edge even without stepping.
      if (state == RUN) done_nxt = (y_nxt >= LIMIT_Y);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        x_q    <= XW'(1);
        y_q    <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (start) begin
        x_q    <= init_x;
        y_q    <= init_y;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        x_q    <= x_nxt;
        y_q    <= y_nxt;
        done_q <= done_nxt;
        ovf_q  <= ovf_nxt;
      end
    end

    assign x_o[i*XW +: XW] = x_q;
    assign y_o[i*YW +: YW] = y_q;
    assign done[i]         = done_q;
    assign ovf[i]          = ovf_q;

`ifdef ACCUM_INV_CHK_EN
    localparam int CW = (XW > YW) ? XW : YW;
    logic inv_q;

    // Evaluated on next-state values so the flag lines up with done.
    always_ff @(posedge clk) begin
      if (rst || start) inv_q <= 1'b0;
      else              inv_q <= inv_q | (done_nxt & (CW'(x_nxt) < CW'(y_nxt)));
    end

    assign inv_err[i] = inv_q;
`endif
  end

endmodule
